// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two per-source byte FIFOs drained round-robin
// into one UART transmitter, one start pulse per byte.

module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wdata,
  input  logic       accept,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE =
    DEPTH_LOG2'(1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  at_full;
  logic                  push;
  logic                  pull;

  // fullness is judged on the pre-edge count, even if a pop
  // happens on the same edge
  assign at_full = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign push    = accept & ~at_full;
  assign pull    = pop & ~empty;
  assign head    = mem[rptr];

  // occupancy after this edge
  always_comb begin
    cnt_nxt = cnt;
    unique case ({push, pull})
      2'b10:   cnt_nxt = cnt + CNT_ONE;
      2'b01:   cnt_nxt = cnt - CNT_ONE;
      default: cnt_nxt = cnt;
    endcase
  end

  // pointers, count and the registered full/drop flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      full <= 1'b0;
      drop <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pull) rptr <= rptr + PTR_ONE;
      cnt  <= cnt_nxt;
      full <= (cnt_nxt == CNT_FULL);
      drop <= accept & at_full;
    end
  end

  // byte storage; slots are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

endmodule

module uart_tx_arbiter #(
  parameter int DEPTH_LOG2   = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic       lpc_clk,
  input  logic       lpc_rst,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  output logic       a_full,
  output logic       b_full,
  output logic       a_drop,
  output logic       b_drop,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       host_busy,
  output logic       grant
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [TW-1:0] tmo;
  logic       a_valid_q;
  logic       b_valid_q;
  logic       a_accept;
  logic       b_accept;
  logic [7:0] a_head;
  logic [7:0] b_head;
  logic       a_empty;
  logic       b_empty;
  logic       issue;
  logic       pick_b;
  logic       a_pop;
  logic       b_pop;

  assign a_accept = a_valid & ~a_valid_q;
  assign b_accept = b_valid & ~b_valid_q;
  assign a_pop    = issue & ~pick_b;
  assign b_pop    = issue & pick_b;

  // valid history so a held-high valid yields one byte
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      a_valid_q <= a_valid;
      b_valid_q <= b_valid;
    end
  end

  uart_tx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo_a (
    .clk    (lpc_clk),
    .rst_n  (lpc_rst),
    .wdata  (a_data),
    .accept (a_accept),
    .pop    (a_pop),
    .head   (a_head),
    .empty  (a_empty),
    .full   (a_full),
    .drop   (a_drop)
  );

  uart_tx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo_b (
    .clk    (lpc_clk),
    .rst_n  (lpc_rst),
    .wdata  (b_data),
    .accept (b_accept),
    .pop    (b_pop),
    .head   (b_head),
    .empty  (b_empty),
    .full   (b_full),
    .drop   (b_drop)
  );

  // scheduler next state and issue decision
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    pick_b    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!tx_busy && !(a_empty && b_empty)) begin
          issue = 1'b1;
          unique case (1'b1)
            a_empty: pick_b = 1'b1;
            b_empty: pick_b = 1'b0;
            default: pick_b = ~grant;
          endcase
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (tmo == TMO_LAST) begin
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register and busy-wait timeout counter
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      state <= IDLE;
      tmo   <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT_BUSY) tmo <= tmo + TMO_ONE;
      else                    tmo <= '0;
    end
  end

  // transmitter-facing byte, start pulse and last grant
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      grant    <= 1'b1;
    end else begin
      tx_start <= issue;
      if (issue) begin
        tx_data <= pick_b ? b_head : a_head;
        grant   <= pick_b;
      end
    end
  end

  assign host_busy = (state != IDLE) | tx_busy | a_full;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random and directed stimulus checked by a
// queue-based reference model and a decoupled output monitor.

module tb_uart_tx_arbiter;

  localparam int DEPTH = 4;
  localparam int TMO   = 4;

  logic       lpc_clk = 1'b0;
  logic       lpc_rst;
  logic [7:0] a_data;
  logic       a_valid;
  logic [7:0] b_data;
  logic       b_valid;
  logic       a_full;
  logic       b_full;
  logic       a_drop;
  logic       b_drop;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       host_busy;
  logic       grant;

  uart_tx_arbiter #(
    .DEPTH_LOG2   (2),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .lpc_clk   (lpc_clk),
    .lpc_rst   (lpc_rst),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .a_full    (a_full),
    .b_full    (b_full),
    .a_drop    (a_drop),
    .b_drop    (b_drop),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .host_busy (host_busy),
    .grant     (grant)
  );

  always #5 lpc_clk = ~lpc_clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // UART model
  bit uart_on   = 1'b1;
  bit rnd       = 1'b0;
  bit hold_busy = 1'b0;
  int pend      = 0;
  int left      = 0;
  int ulen      = 10;

  always @(negedge lpc_clk) begin
    if (tx_start && uart_on) begin
      pend = rnd ? $urandom_range(1, 6) : 2;
      ulen = rnd ? $urandom_range(1, 8) : 10;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) left = ulen;
    end
    if (left > 0) begin
      left--;
      tx_busy = 1'b1 | hold_busy;
    end else begin
      tx_busy = hold_busy;
    end
  end

  // reference model: byte queues plus transmitter ownership
  typedef struct {
    logic [7:0] d;
    logic       g;
    int         c;
  } exp_t;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  exp_t       expq[$];
  int  cyc = 0;
  bit  pa, pb, mg;
  bit  m_owned, m_got_busy;
  int  m_start;
  bit  m_full_a, m_full_b, m_drop_a, m_drop_b;

  always @(posedge lpc_clk) begin
    bit acc_a, acc_b, sel;
    int na, nb;
    logic [7:0] d;
    cyc++;
    if (!lpc_rst) begin
      qa.delete();
      qb.delete();
      expq.delete();
      pa = 0; pb = 0; mg = 1;
      m_owned = 0; m_got_busy = 0;
      m_full_a = 0; m_full_b = 0;
      m_drop_a = 0; m_drop_b = 0;
    end else begin
      acc_a = a_valid && !pa;
      acc_b = b_valid && !pb;
      na = qa.size();
      nb = qb.size();
      m_drop_a = acc_a && (na == DEPTH);
      m_drop_b = acc_b && (nb == DEPTH);
      if (m_owned) begin
        if (!m_got_busy) begin
          if (tx_busy) m_got_busy = 1;
          else if (cyc - m_start == TMO) m_owned = 0;
        end else if (!tx_busy) begin
          m_owned = 0;
        end
      end else if (!tx_busy && (na + nb) > 0) begin
        sel = (na > 0 && nb > 0) ? !mg : (na == 0);
        if (sel) d = qb.pop_front();
        else     d = qa.pop_front();
        mg = sel;
        m_owned = 1;
        m_got_busy = 0;
        m_start = cyc;
        expq.push_back('{d: d, g: sel, c: cyc});
      end
      if (acc_a && na < DEPTH) qa.push_back(a_data);
      if (acc_b && nb < DEPTH) qb.push_back(b_data);
      pa = a_valid;
      pb = b_valid;
      m_full_a = (qa.size() == DEPTH);
      m_full_b = (qb.size() == DEPTH);
    end
  end

  // monitor
  logic [8:0] seen[$];
  int         seen_cyc[$];
  int         drops_a = 0;
  int         drops_b = 0;

  always begin
    exp_t e;
    @(posedge lpc_clk);
    #1;
    chk("a_full", a_full, m_full_a);
    chk("b_full", b_full, m_full_b);
    chk("a_drop", a_drop, m_drop_a);
    chk("b_drop", b_drop, m_drop_b);
    chk("host_busy", host_busy,
        m_owned | tx_busy | m_full_a);
    if (a_drop) drops_a++;
    if (b_drop) drops_b++;
    if (tx_start) begin
      seen.push_back({grant, tx_data});
      seen_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_start: data %0h, required none",
                 tx_data);
      end else begin
        e = expq.pop_front();
        chk("tx_data", tx_data, e.d);
        chk("grant", grant, e.g);
        chk("start_cycle", cyc, e.c);
      end
    end
  end

  task automatic push_a(input logic [7:0] d);
    @(negedge lpc_clk);
    a_data = d;
    a_valid = 1'b1;
    @(negedge lpc_clk);
    a_valid = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    @(negedge lpc_clk);
    b_data = d;
    b_valid = 1'b1;
    @(negedge lpc_clk);
    b_valid = 1'b0;
  endtask

  task automatic push_ab(input logic [7:0] da,
                         input logic [7:0] db);
    @(negedge lpc_clk);
    a_data = da;
    b_data = db;
    a_valid = 1'b1;
    b_valid = 1'b1;
    @(negedge lpc_clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(qa.size() == 0 && qb.size() == 0 && !m_owned &&
             !tx_busy && pend == 0 && left == 0 &&
             expq.size() == 0) && n < 400) begin
      @(negedge lpc_clk);
      n++;
    end
    if (n >= 400) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: busy after %0d cycles, required idle",
               n);
    end
    repeat (2) @(negedge lpc_clk);
  endtask

  task automatic do_reset();
    @(negedge lpc_clk);
    lpc_rst = 1'b0;
    repeat (2) @(negedge lpc_clk);
    lpc_rst = 1'b1;
  endtask

  logic [8:0] exp_rr [4];
  logic [8:0] s;

  initial begin
    lpc_rst = 1'b0;
    a_data = 8'h00;
    b_data = 8'h00;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tx_busy = 1'b0;
    repeat (3) @(negedge lpc_clk);
    #1;
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_grant", grant, 1'b1);
    lpc_rst = 1'b1;

    // single host byte, valid held high
    seen.delete();
    drops_a = 0;
    @(negedge lpc_clk);
    a_data = 8'h41;
    a_valid = 1'b1;
    repeat (3) @(negedge lpc_clk);
    a_valid = 1'b0;
    wait_idle();
    chk("single_count", seen.size(), 1);
    if (seen.size() > 0) begin
      s = seen[0];
      chk("single_byte", s, 9'h041);
    end
    chk("single_drop", drops_a, 0);
    chk("idle_host_busy", host_busy, 1'b0);

    // round-robin tie from reset
    do_reset();
    seen.delete();
    push_ab(8'h10, 8'h20);
    push_ab(8'h11, 8'h21);
    wait_idle();
    exp_rr[0] = 9'h010;
    exp_rr[1] = 9'h120;
    exp_rr[2] = 9'h011;
    exp_rr[3] = 9'h121;
    chk("rr_count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      s = seen[i];
      chk("rr_order", s, exp_rr[i]);
    end

    // overflow while the transmitter is held busy
    seen.delete();
    drops_a = 0;
    hold_busy = 1'b1;
    repeat (2) @(negedge lpc_clk);
    for (int i = 1; i <= 4; i++) push_a(8'(i));
    chk("ovf_full", a_full, 1'b1);
    chk("ovf_host_busy", host_busy, 1'b1);
    chk("ovf_no_drop", drops_a, 0);
    push_a(8'h05);
    @(negedge lpc_clk);
    chk("ovf_drop", drops_a, 1);
    hold_busy = 1'b0;
    wait_idle();
    chk("ovf_count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      s = seen[i];
      chk("ovf_bytes", s, 9'(i + 1));
    end
    seen.delete();
    for (int i = 6; i <= 9; i++) push_a(8'(i));
    wait_idle();
    chk("wrap_count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      s = seen[i];
      chk("wrap_bytes", s, 9'(i + 6));
    end

    // busy never rises: timeout then next byte
    seen.delete();
    seen_cyc.delete();
    uart_on = 1'b0;
    push_b(8'h55);
    push_b(8'h56);
    wait_idle();
    uart_on = 1'b1;
    chk("tmo_count", seen.size(), 2);
    if (seen.size() == 2) begin
      s = seen[0];
      chk("tmo_first", s, 9'h155);
      s = seen[1];
      chk("tmo_second", s, 9'h156);
      chk("tmo_gap", seen_cyc[1] - seen_cyc[0], TMO + 1);
    end

    // reset during WAIT_DONE
    push_a(8'h31);
    push_a(8'h32);
    push_a(8'h33);
    for (int n = 0; n < 40 && !(m_owned && m_got_busy); n++)
      @(negedge lpc_clk);
    chk("mid_reached_done", m_owned && m_got_busy, 1'b1);
    @(negedge lpc_clk);
    seen.delete();
    lpc_rst = 1'b0;
    #1;
    chk("mid_tx_start", tx_start, 1'b0);
    chk("mid_tx_data", tx_data, 8'h00);
    chk("mid_grant", grant, 1'b1);
    chk("mid_a_full", a_full, 1'b0);
    chk("mid_b_full", b_full, 1'b0);
    chk("mid_a_drop", a_drop, 1'b0);
    chk("mid_b_drop", b_drop, 1'b0);
    chk("mid_host_busy", host_busy, tx_busy);
    repeat (2) @(negedge lpc_clk);
    lpc_rst = 1'b1;
    repeat (30) @(negedge lpc_clk);
    chk("mid_no_start", seen.size(), 0);
    push_a(8'h40);
    wait_idle();
    chk("mid_after_count", seen.size(), 1);
    if (seen.size() > 0) begin
      s = seen[0];
      chk("mid_after_byte", s, 9'h040);
    end

    // random traffic with random transmitter timing
    rnd = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge lpc_clk);
      if ($urandom_range(0, 2) == 0) a_valid = ~a_valid;
      if ($urandom_range(0, 2) == 0) b_valid = ~b_valid;
      a_data = 8'($urandom);
      b_data = 8'($urandom);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    rnd = 1'b0;
    wait_idle();
    chk("scoreboard_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
